// File: rtl/ps2_key_tracker_if.sv
// Byte stream from PS2_Controller and decoded make/break event bundle
// for the key tracker.
interface ps2_key_tracker_if #(
   parameter int IDX_W = 2
);
   logic [7:0]       received_data;
   logic             received_data_en;
   logic             event_valid;
   logic             event_break;
   logic [8:0]       event_code;
   logic [IDX_W-1:0] event_slot;

   modport master (
      output received_data, received_data_en,
      input  event_valid, event_break, event_code, event_slot
   );

   modport slave (
      input  received_data, received_data_en,
      output event_valid, event_break, event_code, event_slot
   );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 make/break parser with a held-key slot table for the synth.
// KEY_TRACKER_STEAL_EN: when full, a make replaces the oldest-allocated slot.
module ps2_key_tracker #(
   parameter int NUM_VOICES = 4,
   parameter int IDX_W      = 2
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   ps2_key_tracker_if.slave        bus,
   input  logic                    clear_all,
   output logic [7:0]              last_data_received,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic [9*NUM_VOICES-1:0] voice_code,
   output logic                    overflow
);
   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t           state, state_n;
   logic [7:0]       rx;
   logic             rx_en;
   logic             ign, fire, fire_brk;
   logic [8:0]       code;
   logic [8:0]       slot_code [NUM_VOICES];
   logic             hit, free;
   logic [IDX_W-1:0] hit_idx, free_idx;
   logic             alloc, clr, drop;
   logic [IDX_W-1:0] alloc_idx;
   logic             ev_valid, ev_break;
   logic [8:0]       ev_code;
   logic [IDX_W-1:0] ev_slot;

   assign rx    = bus.received_data;
   assign rx_en = bus.received_data_en;

   assign bus.event_valid = ev_valid;
   assign bus.event_break = ev_break;
   assign bus.event_code  = ev_code;
   assign bus.event_slot  = ev_slot;

   always_comb begin
      ign = rx inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   end

   always_comb begin
      state_n  = state;
      fire     = 1'b0;
      fire_brk = 1'b0;
      code     = {1'b0, rx};
      if (rx_en) begin
         unique case (1'b1)
            ign:          state_n = IDLE;
            rx == 8'hE0:  state_n = EXT;
            rx == 8'hF0:  state_n = (state == EXT) ? EXT_BRK : BRK;
            default: begin
               fire     = 1'b1;
               fire_brk = state inside {BRK, EXT_BRK};
               code     = {state inside {EXT, EXT_BRK}, rx};
               state_n  = IDLE;
            end
         endcase
      end
   end

   // descending scan so the lowest matching/free index wins
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voice_active[i] && slot_code[i] == code) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!voice_active[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

`ifdef KEY_TRACKER_STEAL_EN
   // age = number of still-active slots allocated after this one
   logic [IDX_W-1:0] age [NUM_VOICES];
   logic [IDX_W-1:0] old_idx;

   always_comb begin
      old_idx = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (age[i] == IDX_W'(NUM_VOICES - 1)) old_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
      end else if (!clear_all) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (alloc) begin
               if (alloc_idx == IDX_W'(i)) age[i] <= '0;
               else if (voice_active[i]) age[i] <= age[i] + 1'b1;
            end else if (clr) begin
               if (voice_active[i] && age[i] > age[hit_idx])
                  age[i] <= age[i] - 1'b1;
            end
         end
      end
   end
`endif

   always_comb begin
      drop      = fire && !fire_brk && !hit && !free;
      clr       = fire && fire_brk && hit;
      alloc     = fire && !fire_brk && !hit && free;
      alloc_idx = free_idx;
`ifdef KEY_TRACKER_STEAL_EN
      if (drop) begin
         alloc     = 1'b1;
         alloc_idx = old_idx;
      end
`endif
   end

   always_comb begin
      voice_code = '0;
      for (int i = 0; i < NUM_VOICES; i++) voice_code[9*i +: 9] = slot_code[i];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state              <= IDLE;
         last_data_received <= '0;
         voice_active       <= '0;
         overflow           <= 1'b0;
         ev_valid           <= 1'b0;
         ev_break           <= 1'b0;
         ev_code            <= '0;
         ev_slot            <= '0;
         for (int i = 0; i < NUM_VOICES; i++) slot_code[i] <= '0;
      end else begin
         ev_valid <= 1'b0;
         if (rx_en) last_data_received <= rx;
         if (clear_all) begin
            state        <= IDLE;
            voice_active <= '0;
            overflow     <= 1'b0;
         end else begin
            state <= state_n;
            if (drop) overflow <= 1'b1;
            if (alloc || clr) begin
               ev_valid <= 1'b1;
               ev_break <= clr;
               ev_code  <= code;
               ev_slot  <= clr ? hit_idx : alloc_idx;
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (alloc && alloc_idx == IDX_W'(i)) begin
                  voice_active[i] <= 1'b1;
                  slot_code[i]    <= code;
               end
               if (clr && hit_idx == IDX_W'(i)) voice_active[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Polyphonic key-state tracker for the synth front end. It sits directly after PS2_Controller, consuming its received_data / received_data_en byte stream. It parses PS/2 set-2 scan-code sequences (E0 extended prefix, F0 break prefix) into make/break events, and keeps a table of up to NUM_VOICES currently held keys for the voice allocator. It also retains the last raw byte for HEX display.

Parameters:
NUM_VOICES, 4, number of simultaneously tracked held keys (slots); legal 1..16
IDX_W, 2, slot index width; must equal ceil(log2(NUM_VOICES)), minimum 1

Ports:
CLOCK_50  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
received_data  input  8  byte from PS2_Controller
received_data_en  input  1  one-cycle strobe: received_data valid
clear_all  input  1  synchronous all-notes-off request
last_data_received  output  8  last raw byte accepted (any value)
event_valid  output  1  one-cycle pulse: complete make/break decoded
event_break  output  1  1 = break, 0 = make; valid with event_valid
event_code  output  9  {ext, code}; valid with event_valid
event_slot  output  IDX_W  slot written/cleared; valid with event_valid
voice_active  output  NUM_VOICES  bit i = slot i holds a key
voice_code  output  9*NUM_VOICES  slot i code at [9i+8:9i]
overflow  output  1  sticky: a make was dropped because the table was full

Behaviour:
- Reset: all outputs 0; voice_code all 0; parser in IDLE.
- last_data_received <= received_data on every received_data_en, including prefixes and ignored bytes.
- Parser states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on received_data_en.
  - IDLE: E0 -> EXT; F0 -> BRK; other -> make of {0,byte}, back to IDLE.
  - EXT: F0 -> EXT_BRK; other -> make of {1,byte} -> IDLE.
  - BRK: other -> break of {0,byte} -> IDLE.
  - EXT_BRK: other -> break of {1,byte} -> IDLE.
- Ignore set {00, AA, E1, EE, FA, FE, FF}: the byte produces no event and the parser returns to IDLE from any state. The E1 pause sequence is not tracked.
- E0 or F0 received in an unexpected state (e.g. F0 in BRK) restarts parsing from IDLE with that byte.
- Make event:
  - If the code is already held in an active slot (typematic repeat): no event, table unchanged.
  - Else allocate the lowest-index free slot: voice_active[i] <= 1, voice_code[i] <= code, event_valid pulse with event_slot = i.
  - If no slot is free: drop the make (or steal; see Optional Feature), overflow <= 1, no event_valid.
- Break event: clear the matching active slot (voice_active <= 0; voice_code retained), event_valid pulse with that slot. A break with no matching slot produces no pulse and no change.
- Latency: table and event outputs update on the same edge that samples the final byte's strobe; event_valid is high exactly 1 cycle.
- clear_all: clears voice_active, overflow and the parser (to IDLE) on that edge. A byte strobed in the same cycle updates last_data_received but is otherwise discarded. reset has priority over clear_all.
- Reset mid-sequence (e.g. after E0) discards the partial sequence.

Optional Feature:
KEY_TRACKER_STEAL_EN
- Defined: per-slot allocation age is kept. A make arriving when the table is full replaces the oldest-allocated slot, event_valid pulses with that slot, and overflow is still set.
- Undefined: the make is dropped as described above, and no age logic is built.

Test Plan:
- Bytes 1C -> slot0 = 0x01C, voice_active = 0001, event_valid with break = 0, slot = 0, last_data_received = 1C.
- Then F0, 1C -> voice_active = 0000, one break pulse with code 0x01C and slot 0; no pulse on the F0 byte.
- E0 75, then E0 F0 75 -> make then break of code 0x175; last_data_received = 75.
- Makes 1C, 1B, 23, 2B, then 34 (NUM_VOICES = 4) -> slots 0..3 filled, 34 dropped, overflow = 1. With the macro defined, slot0 becomes 0x034 instead.
- 1C, 1C, 1C (typematic) -> exactly one event_valid pulse; AA mid-stream after F0 -> no event, parser back to IDLE.
- Two keys held, then clear_all together with a byte 1B strobe -> voice_active = 0000, overflow = 0, no event, last_data_received = 1B.
